display_page_scheduler: RTL
===========================

// Module: display_page_scheduler
// PURPOSE
//  Shares the 8-digit 7-seg display between N_SRC requesters by rotating display pages.
//  Each requester offers a 32-bit hex word (8 nibbles, digit 0 = bits [3:0]).
//  The scheduler picks sources round-robin, shows each one for a programmable dwell time,
//  and drives the display block's din and div_value inputs. Sits directly upstream of display.
// PARAMETERS
//  N_SRC        4            number of requesters, 2..8
//  SEL_W        $clog2(N_SRC) width of the source index
//  DEFAULT_DIV  32'd100000   div_value_o after reset, and the value used when div_cfg==0
// PORTS
//  clk          in   1          system clock; all logic on the rising edge
//  rst          in   1          synchronous, active-high reset
//  dwell_cycles in   32         clk cycles per page; 0 is treated as 1
//  div_cfg      in   32         digit-scan divider for display; 0 selects DEFAULT_DIV
//  src_data     in   32*N_SRC   source i word = src_data[32*i +: 32]
//  src_valid    in   N_SRC      source i has a word to show (level)
//  src_ack      out  N_SRC      1-cycle pulse: src_data[i] captured this cycle
//  din_o        out  32         word to display.din
//  div_value_o  out  32         divider to display.div_value
//  src_sel_o    out  SEL_W      index of the source currently shown
//  blank_o      out  1          1 = nothing captured yet; the consumer blanks the digits (an=all 1)
// BEHAVIOUR
//  Reset values: din_o=0, div_value_o=DEFAULT_DIV, src_sel_o=N_SRC-1, src_ack=0, blank_o=1,
//    dwell counter=0, state=SCAN.
//  Rotation pointer = src_sel_o. Search order: sel+1, sel+2, ... wrapping mod N_SRC; sel itself last.
//  FSM
//   SCAN: evaluate src_valid combinationally in the search order.
//     Hit at index k, registered on the same edge:
//       - din_o <= src_data[k], src_sel_o <= k, src_ack[k] = 1 for this cycle
//       - blank_o <= 0, div_value_o <= (div_cfg==0 ? DEFAULT_DIV : div_cfg)
//       - cnt <= max(dwell_cycles,1) - 1; next state SHOW
//     No hit: every output holds its previous value (last page stays shown); stay in SCAN and
//       retry on every cycle.
//   SHOW: if src_valid[src_sel_o]==1, din_o <= that word and src_ack pulses for that source (live
//     refresh), otherwise din_o holds. When cnt==0, next state SCAN; otherwise cnt <= cnt-1.
//     div_value_o is constant throughout SHOW; it changes only on a page capture (no scan glitch).
//  Latency: a page is shown for exactly max(dwell,1) SHOW cycles plus 1 SCAN cycle.
//    With all sources valid the period is dwell+1 cycles per source.
//  src_ack is one-hot or zero; it is never asserted for a source whose src_valid is low.
//  dwell_cycles is sampled only at capture, so changing it mid-page does not affect the current page.
//  Single valid source: it is re-selected every page (search wraps to sel itself) and gets one
//    capture ack per page.
//  src_valid[k] dropping during SHOW of k: the page keeps its last word until the dwell expires.
//  rst mid-page: all state returns to reset values on the next edge; blank_o=1 until the next capture.
//  Arithmetic: the dwell counter is 32-bit unsigned down-counter, never decrements below 0.
// STRUCTURE
//  display_pkg: state encoding (ST_SCAN, ST_SHOW), WORD_W=32, DEFAULT_DIV constant.
//  Sub-module rr_pick (combinational): inputs req[N_SRC], last[SEL_W];
//    outputs hit, idx[SEL_W] (first requester after last, wrapping).
//  Top level: FSM, dwell counter, output registers, and the ack decode.
// TESTING
//  1. Reset, N_SRC=4, dwell=3, all valid, words 0x11111111..0x44444444
//     -> din_o sequence src0,1,2,3,0, each held 4 cycles; ack pulses on capture cycles.
//  2. Only src2 valid -> src_sel_o stays 2; src_ack[2] pulses every cycle during SHOW (live refresh)
//     and at each capture.
//  3. No source valid after reset -> blank_o=1, din_o=0, div_value_o=DEFAULT_DIV indefinitely.
//     Raise src1 -> captured on the next edge, blank_o=0.
//  4. dwell_cycles=0, div_cfg=0 -> each page lasts 1 SHOW cycle; div_value_o=DEFAULT_DIV.
//     div_cfg=500 -> applied only at the next capture.
//  5. Assert rst during SHOW of src3 -> next cycle: reset values, state SCAN; first capture then
//     restarts at src0.
//  6. Change dwell 10->2 mid-page -> current page completes 10 cycles; the next page lasts 2.

Source files
------------

// File: rtl/display_page_scheduler_pkg.sv
// Shared definitions for the display page scheduler: FSM encoding, word width
// and the default digit-scan divider.
package display_page_scheduler_pkg;

  localparam int unsigned WORD_W = 32;

  // Divider used after reset and whenever div_cfg is programmed to 0.
  localparam logic [WORD_W-1:0] DEFAULT_DIV = 32'd100000;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/display_page_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req  - request vector, one bit per source
//   last - index of the previously served source
//   hit  - at least one request is pending
//   idx  - first requester after last, wrapping; last itself is checked last
module display_page_scheduler_rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             hit,
  output logic [SEL_W-1:0] idx
);

  int unsigned k;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    hit = 1'b0;
    idx = last;
    k   = 0;
    for (int unsigned off = N_SRC; off >= 1; off--) begin
      k = (32'(last) + off) % N_SRC;
      if (req[SEL_W'(k)]) begin
        hit = 1'b1;
        idx = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/display_page_scheduler.sv
// Rotates display pages of the 8-digit 7-seg display between N_SRC requesters.
// Each captured source is shown for max(dwell_cycles,1) cycles, then the next
// valid source (round-robin) is captured.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   dwell_cycles  - cycles per page (0 behaves as 1), sampled at capture
//   div_cfg       - digit-scan divider, 0 selects DEFAULT_DIV, sampled at capture
//   src_data      - packed source words, source i at [32*i +: 32]
//   src_valid     - per-source "has a word" level
//   src_ack       - one-hot pulse in the cycle a source word is taken
//   din_o         - word to the display
//   div_value_o   - divider to the display
//   src_sel_o     - index of the source currently shown
//   blank_o       - nothing captured since reset
module display_page_scheduler
  import display_page_scheduler_pkg::*;
#(
  parameter int unsigned       N_SRC       = 4,
  parameter int unsigned       SEL_W       = $clog2(N_SRC),
  parameter logic [WORD_W-1:0] DEFAULT_DIV = display_page_scheduler_pkg::DEFAULT_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W-1:0]         dwell_cycles,
  input  logic [WORD_W-1:0]         div_cfg,
  input  logic [WORD_W*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]          src_valid,
  output logic [N_SRC-1:0]          src_ack,
  output logic [WORD_W-1:0]         din_o,
  output logic [WORD_W-1:0]         div_value_o,
  output logic [SEL_W-1:0]          src_sel_o,
  output logic                      blank_o
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] din_d, div_d;
  logic [SEL_W-1:0]  sel_d;
  logic              blank_d;

  logic              pick_hit;
  logic [SEL_W-1:0]  pick_idx;
  logic [WORD_W-1:0] src_word [N_SRC];
  logic [WORD_W-1:0] dwell_m1;
  logic [WORD_W-1:0] div_eff;

  // Unpack the source words for indexed selection.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_word[i] = src_data[i*WORD_W +: WORD_W];
    end
  end

  // Capture-time parameters: dwell of 0 counts as 1, div_cfg of 0 means default.
  assign dwell_m1 = (dwell_cycles == '0) ? '0 : dwell_cycles - 32'd1;
  assign div_eff  = (div_cfg == '0) ? DEFAULT_DIV : div_cfg;

  display_page_scheduler_rr_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req  (src_valid),
    .last (src_sel_o),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  // Next-state, register updates and the ack decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_o;
    div_d   = div_value_o;
    sel_d   = src_sel_o;
    blank_d = blank_o;
    src_ack = '0;

    case (state_q)
      ST_SCAN: begin
        if (pick_hit) begin
          din_d             = src_word[pick_idx];
          sel_d             = pick_idx;
          blank_d           = 1'b0;
          div_d             = div_eff;
          cnt_d             = dwell_m1;
          src_ack[pick_idx] = 1'b1;
          state_d           = ST_SHOW;
        end
      end
      ST_SHOW: begin
        // Live refresh of the shown source while it stays valid.
        if (src_valid[src_sel_o]) begin
          din_d              = src_word[src_sel_o];
          src_ack[src_sel_o] = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = ST_SCAN;
      end
    endcase

    // Nothing is taken while reset is applied.
    if (rst) begin
      src_ack = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      din_o       <= '0;
      div_value_o <= DEFAULT_DIV;
      src_sel_o   <= SEL_W'(N_SRC - 1);
      blank_o     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_o       <= din_d;
      div_value_o <= div_d;
      src_sel_o   <= sel_d;
      blank_o     <= blank_d;
    end
  end

endmodule
